halt_dump_sequencer: RTL and testbench

Run-control sequencer for the five-stage pipeline CPU. Detects the halt instruction word at fetch, freezes the PC and flushes the pipeline, then waits for in-flight instructions to retire. It then borrows the data-memory read port to stream every main-memory word out over a valid/ready channel to the bench/file writer. It sits beside the IF stage, PC and MainMemory, and owns the PC-hold and IF_ID-kill controls plus a second read path into memory.

---
 rtl/halt_dump_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_halt_dump_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/halt_dump_sequencer.sv
// -----------------------------------------------------------------------------
// halt_dump_sequencer
//
// Run-control sequencer for the five-stage pipeline CPU.
//
// While the program runs, it counts executed cycles and watches the fetch slot
// for the halt instruction word. When a real (non-squashed) halt word is
// fetched, it takes these steps in order:
//   1. It freezes the PC and kills the IF_ID load in that same cycle, so the
//      halt word never enters the pipeline.
//   2. It waits DRAIN_CYCLES cycles so the older instructions in ID/EX/MEM/WB
//      can retire.
//   3. It borrows the data-memory read port and streams every memory word,
//      address 0 first, over a valid/ready channel.
//   4. It raises a sticky done flag.
//
// Ports
//   clk            in   single clock, all state on rising edge
//   reset          in   synchronous, active-high
//   if_instruction in   [31:0] instruction word from InstructionRAM
//   if_valid       in   fetch slot is real (not squashed by branch flush)
//   pc_hold        out  1 = PC write disabled                  (combinational)
//   if_kill        out  1 = IF_ID loads a nop                  (combinational)
//   mem_rd_en      out  dump read request to MainMemory        (combinational)
//   mem_addr       out  [ADDR_W-1:0] dump word address         (combinational)
//   mem_rd_data    in   [31:0] read data, valid cycle after mem_rd_en
//   out_valid      out  dump word available                    (registered)
//   out_ready      in   consumer accepts when out_valid && out_ready
//   out_addr       out  [ADDR_W-1:0] word address of out_data  (registered)
//   out_data       out  [31:0] dumped word                     (registered)
//   cycle_count    out  [31:0] executed-cycle counter          (registered)
//   done           out  dump complete, sticky until reset      (registered)
// -----------------------------------------------------------------------------
module halt_dump_sequencer #(
  parameter int          MEM_WORDS    = 512,
  parameter int          ADDR_W       = $clog2(MEM_WORDS),
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_instruction,
  input  logic              if_valid,
  output logic              pc_hold,
  output logic              if_kill,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [31:0]       cycle_count,
  output logic              done
);

  // The drain counter must be able to hold DRAIN_CYCLES. It is kept at
  // least 1 bit wide so that degenerate parameter values still elaborate.
  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [CNT_W-1:0]  LP_DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0]  LP_CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]   LP_RP_END     = (ADDR_W + 1)'(MEM_WORDS);
  localparam logic [ADDR_W:0]   LP_RP_ONE     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LP_LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [31:0]       r_cycle_count;
  logic [CNT_W-1:0]  r_drain_cnt;

  // The read pointer is one bit wider than an address, so that it can reach
  // MEM_WORDS, meaning "all reads issued".
  logic [ADDR_W:0]   r_rp;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_addr;

  // 2-entry output FIFO, built as a head register (which drives the outputs
  // directly) and a skid register behind it.
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_data;
  logic              r_skid_valid;
  logic [ADDR_W-1:0] r_skid_addr;
  logic [31:0]       r_skid_data;

  logic              r_done;

  logic              w_halt_det;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_last_pop;
  logic [2:0]        w_load;

  assign w_halt_det = (r_state == ST_RUN) && if_valid && (if_instruction == HALT_WORD);
  assign w_pop      = r_out_valid && out_ready;
  // Read data for a request comes back the cycle after issue. It is captured
  // on the edge that ends that cycle.
  assign w_push     = r_inflight;

  // This is the number of words that will occupy the FIFO or still be
  // inflight after this edge, not counting any read issued in this cycle.
  // The pop term can never underflow the sum, because a pop requires
  // r_out_valid.
  assign w_load = {2'b00, r_out_valid} + {2'b00, r_skid_valid}
                + {2'b00, r_inflight}  - {2'b00, w_pop};

  // A read is only issued when its data is guaranteed a FIFO slot on return.
  // This is why the 2-entry FIFO can never overflow.
  assign w_issue = (r_state == ST_DUMP) && (r_rp < LP_RP_END) && (w_load < 3'd2);

  assign w_last_pop = (r_state == ST_DUMP) && w_pop && (r_out_addr == LP_LAST_ADDR);

  assign out_valid   = r_out_valid;
  assign out_addr    = r_out_addr;
  assign out_data    = r_out_data;
  assign cycle_count = r_cycle_count;
  assign done        = r_done;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic and the combinational pipeline/memory controls
  always_comb begin
    w_state_nxt = r_state;
    pc_hold     = 1'b1;
    if_kill     = 1'b1;
    mem_rd_en   = 1'b0;
    mem_addr    = {ADDR_W{1'b0}};
    case (r_state)
      ST_RUN: begin
        // Hold and kill go high in the detect cycle itself, so the halt word
        // is never loaded into IF_ID and the PC never moves past it.
        pc_hold = w_halt_det;
        if_kill = w_halt_det;
        if (w_halt_det) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt <= LP_CNT_ONE) begin
          w_state_nxt = ST_DUMP;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DUMP: begin
        mem_rd_en = w_issue;
        mem_addr  = r_rp[ADDR_W-1:0];
        if (w_last_pop) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DUMP;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Executed-cycle counter: counts every RUN cycle, including the detect
  // cycle, saturates at all-ones, and freezes once the CPU has halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= 32'd0;
    end else if ((r_state == ST_RUN) && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  // Drain down-counter: loaded on halt detection, then counts the DRAIN
  // cycles down to the exit condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drain_cnt <= {CNT_W{1'b0}};
    end else if (w_halt_det) begin
      r_drain_cnt <= LP_DRAIN_LOAD;
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != {CNT_W{1'b0}})) begin
      r_drain_cnt <= r_drain_cnt - LP_CNT_ONE;
    end
  end

  // Read pointer and inflight tracking. On reset, any read still in flight
  // is forgotten, so its returning data is never captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rp            <= {(ADDR_W + 1){1'b0}};
      r_inflight      <= 1'b0;
      r_inflight_addr <= {ADDR_W{1'b0}};
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_rp[ADDR_W-1:0];
        r_rp            <= r_rp + LP_RP_ONE;
      end
    end
  end

  // Output FIFO: captures returning read data and pops on valid && ready.
  // The head register is what the consumer sees. It only changes when the
  // head is popped or when it is empty, so the outputs stay stable during a
  // stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_addr   <= {ADDR_W{1'b0}};
      r_out_data   <= 32'd0;
      r_skid_valid <= 1'b0;
      r_skid_addr  <= {ADDR_W{1'b0}};
      r_skid_data  <= 32'd0;
    end else if (w_pop) begin
      if (r_skid_valid) begin
        // Advance the skid entry into the head. The new word, if any,
        // refills the skid entry.
        r_out_addr   <= r_skid_addr;
        r_out_data   <= r_skid_data;
        r_skid_valid <= w_push;
        if (w_push) begin
          r_skid_addr <= r_inflight_addr;
          r_skid_data <= mem_rd_data;
        end
      end else if (w_push) begin
        r_out_addr <= r_inflight_addr;
        r_out_data <= mem_rd_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_addr  <= r_inflight_addr;
        r_out_data  <= mem_rd_data;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_addr  <= r_inflight_addr;
        r_skid_data  <= mem_rd_data;
      end
    end
  end

  // Sticky completion flag, set by the pop of the last memory word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else if (w_last_pop) begin
      r_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_halt_dump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_halt_dump_sequencer
//
// Directed bench for halt_dump_sequencer, configured with MEM_WORDS=8 and
// DRAIN_CYCLES=4. Main memory is modelled as a synchronous-read array
// preloaded with word i = 32'hA000_0000 + i. A small scoreboard tracks the
// reads issued and the words popped, so it can check the dump order, the
// data, the stall stability and the FIFO room rule.
// -----------------------------------------------------------------------------
module tb_halt_dump_sequencer;

  localparam int MW = 8;
  localparam int AW = 3;
  localparam int DC = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   if_instruction = 32'd0;
  logic          if_valid = 1'b0;
  logic          pc_hold;
  logic          if_kill;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rd_data = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_data;
  logic [31:0]   cycle_count;
  logic          done;

  logic [31:0]   mem [MW];

  int            n_pass = 0;
  int            n_total = 0;

  int            exp_idx;
  int            issued;
  int            popped;
  logic          stall_prev;
  logic [AW-1:0] stall_addr;
  logic [31:0]   stall_data;

  halt_dump_sequencer #(
    .MEM_WORDS   (MW),
    .ADDR_W      (AW),
    .DRAIN_CYCLES(DC),
    .HALT_WORD   (HALT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .if_instruction(if_instruction),
    .if_valid      (if_valid),
    .pc_hold       (pc_hold),
    .if_kill       (if_kill),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rd_data   (mem_rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .cycle_count   (cycle_count),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read main memory model
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic sb_clear();
    exp_idx    = 0;
    issued     = 0;
    popped     = 0;
    stall_prev = 1'b0;
    stall_addr = '0;
    stall_data = 32'd0;
  endtask

  // Apply out_ready for this cycle, then check stability, pop order/data and
  // the read-issue room rule, then update the bookkeeping for the coming edge.
  task automatic dump_eval(input logic rdy);
    logic pop;
    int   outstanding;
    out_ready = rdy;
    #1;
    pop = out_valid && out_ready;
    if (stall_prev && out_valid) begin
      chk("stall_addr", 32'(out_addr), 32'(stall_addr));
      chk("stall_data", out_data, stall_data);
    end
    if (pop) begin
      chk("pop_addr", 32'(out_addr), 32'(exp_idx));
      chk("pop_data", out_data, 32'hA000_0000 + 32'(exp_idx));
    end
    if (mem_rd_en) begin
      outstanding = issued - popped - (pop ? 1 : 0);
      chk("issue_room", 32'(outstanding < 2), 32'd1);
      chk("issue_addr", 32'(mem_addr), 32'(issued));
      issued++;
    end
    if (pop) begin
      exp_idx++;
      popped++;
    end
    stall_prev = out_valid && !out_ready;
    stall_addr = out_addr;
    stall_data = out_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MW; i++) begin
      mem[i] = 32'hA000_0000 + 32'(i);
    end
    sb_clear();

    // ---- Reset values, then a halt after 10 instructions ----
    reset = 1'b1;
    tick();
    tick();
    chk("rst_pc_hold",   32'(pc_hold),   32'd0);
    chk("rst_if_kill",   32'(if_kill),   32'd0);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_cycle_cnt", cycle_count,    32'd0);
    chk("rst_done",      32'(done),      32'd0);
    reset = 1'b0;

    for (int k = 1; k <= 10; k++) begin
      if_valid = 1'b1;
      if_instruction = NOP;
      settle();
      chk("run_pc_hold", 32'(pc_hold), 32'd0);
      chk("run_count", cycle_count, 32'(k - 1));
      tick();
    end
    if_instruction = HALT;
    settle();
    chk("det_pc_hold", 32'(pc_hold), 32'd1);
    chk("det_if_kill", 32'(if_kill), 32'd1);
    chk("det_count", cycle_count, 32'd10);
    tick();
    if_valid = 1'b0;
    if_instruction = 32'd0;
    settle();
    chk("drain_count", cycle_count, 32'd11);
    chk("drain_pc_hold", 32'(pc_hold), 32'd1);
    chk("drain_if_kill", 32'(if_kill), 32'd1);
    chk("drain_rd_en", 32'(mem_rd_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      chk("drain_rd_en", 32'(mem_rd_en), 32'd0);
    end
    tick();

    // ---- Dump with out_ready held 1 ----
    sb_clear();
    for (int c = 0; c < 12; c++) begin
      dump_eval(1'b1);
      if (c == 0) begin
        chk("d0_rd_en", 32'(mem_rd_en), 32'd1);
        chk("d0_addr", 32'(mem_addr), 32'd0);
      end
      chk("valid_timing", 32'(out_valid), 32'(c >= 2 && c <= 9));
      chk("done_timing", 32'(done), 32'(c >= 10));
      tick();
    end
    settle();
    chk("a_delivered", 32'(exp_idx), 32'd8);
    chk("a_count_frozen", cycle_count, 32'd11);
    chk("a_done_rd_en", 32'(mem_rd_en), 32'd0);
    chk("a_done_pc_hold", 32'(pc_hold), 32'd1);
    chk("a_done_valid", 32'(out_valid), 32'd0);

    // ---- Invalid halt ignored, valid halt 3 cycles later, toggling ready ----
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    chk("b_rst_done", 32'(done), 32'd0);
    chk("b_rst_count", cycle_count, 32'd0);
    reset = 1'b0;
    if_valid = 1'b0;
    if_instruction = HALT;
    settle();
    chk("b_invalid_halt", 32'(pc_hold), 32'd0);
    tick();
    if_valid = 1'b1;
    if_instruction = NOP;
    settle();
    chk("b_still_run", 32'(pc_hold), 32'd0);
    chk("b_count_c2", cycle_count, 32'd1);
    tick();
    tick();
    if_instruction = HALT;
    settle();
    chk("b_valid_halt", 32'(pc_hold), 32'd1);
    chk("b_count_c4", cycle_count, 32'd3);
    tick();
    if_valid = 1'b0;
    if_instruction = 32'd0;
    settle();
    chk("b_count_frozen", cycle_count, 32'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    sb_clear();
    for (int c = 0; c < 80 && done !== 1'b1; c++) begin
      dump_eval(((c % 4) == 0) || ((c % 4) == 3));
      tick();
    end
    settle();
    chk("b_done", 32'(done), 32'd1);
    chk("b_delivered", 32'(exp_idx), 32'd8);
    chk("b_count_end", cycle_count, 32'd4);
    chk("b_done_valid", 32'(out_valid), 32'd0);

    // ---- Halt in first cycle after reset, then reset with addr 3 inflight ----
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    if_valid = 1'b1;
    if_instruction = HALT;
    settle();
    chk("c_first_halt", 32'(pc_hold), 32'd1);
    tick();
    if_valid = 1'b0;
    if_instruction = 32'd0;
    settle();
    chk("c_count_one", cycle_count, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    sb_clear();
    for (int c = 0; c < 4; c++) begin
      dump_eval(1'b1);
      tick();
    end
    chk("c_issued_four", 32'(issued), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    settle();
    chk("c_rst_valid", 32'(out_valid), 32'd0);
    chk("c_rst_count", cycle_count, 32'd0);
    chk("c_rst_done", 32'(done), 32'd0);
    chk("c_rst_pc_hold", 32'(pc_hold), 32'd0);
    chk("c_rst_rd_en", 32'(mem_rd_en), 32'd0);

    // ---- New halt: dump restarts at 0; 50 stalled cycles, then drain ----
    tick();
    if_valid = 1'b1;
    if_instruction = HALT;
    settle();
    chk("d_halt", 32'(pc_hold), 32'd1);
    tick();
    if_valid = 1'b0;
    if_instruction = 32'd0;
    settle();
    chk("d_count", cycle_count, 32'd2);
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    sb_clear();
    for (int c = 0; c < 50; c++) begin
      dump_eval(1'b0);
      if (out_valid) begin
        chk("d_stall_addr0", 32'(out_addr), 32'd0);
      end
      chk("d_stall_done", 32'(done), 32'd0);
      tick();
    end
    chk("d_two_reads", 32'(issued), 32'd2);
    chk("d_valid_held", 32'(out_valid), 32'd1);
    for (int c = 0; c < 40 && done !== 1'b1; c++) begin
      dump_eval(1'b1);
      tick();
    end
    settle();
    chk("d_delivered", 32'(exp_idx), 32'd8);
    chk("d_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
